// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory for the MEM stage with a fixed access latency.
// Holds the pipeline via stall while a latched request counts down, then reports in RESP.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rd_valid,
  output logic        stall,
  output logic        fault
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH    = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        op_write_q;
  logic        req;
  logic        bad;
  logic        access;
  logic [IDX_W-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign req    = mem_read | mem_write;
  assign idx    = addr_q[IDX_W+1:2];
  assign bad    = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH);
  assign access = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Outputs are forced low while rst is high so a held request cannot re-raise stall.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    rd_valid   = 1'b0;
    fault      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall      = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd0) next_state = RESP;
      end
      RESP: begin
        next_state = IDLE;
        rd_valid   = !op_write_q && !bad;
        fault      = bad;
      end
      default: next_state = IDLE;
    endcase
    if (rst) begin
      stall    = 1'b0;
      rd_valid = 1'b0;
      fault    = 1'b0;
    end
  end

  // A simultaneous read+write request is latched as a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      op_write_q <= 1'b0;
      rdata      <= 32'd0;
    end else begin
      if (state == IDLE && req) begin
        addr_q     <= addr;
        wdata_q    <= wdata;
        op_write_q <= mem_write;
        cnt        <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !op_write_q && !bad) rdata <= mem[idx];
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (access && op_write_q && !bad && !rst) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a reference model fills a scoreboard of
// expected RESP outcomes as each request is driven, popped when RESP arrives.
module tb_data_mem_ctrl;

  localparam int DEPTH_WORDS = 256;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        stall;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rv;
    logic        flt;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [int];
  logic [31:0] model_rdata = 32'd0;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid),
    .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: decides the RESP outcome of a request when it is issued.
  task automatic push_expect(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input string name);
    exp_t e;
    logic is_bad;
    int   widx;
    widx   = int'(a[31:2]);
    is_bad = (a[1:0] != 2'b00) || (widx >= DEPTH_WORDS);
    e.name = name;
    e.flt  = is_bad;
    e.rv   = 1'b0;
    if (wr) begin
      if (!is_bad) model_mem[widx] = d;
    end else if (rd && !is_bad) begin
      e.rv = 1'b1;
      model_rdata = model_mem.exists(widx) ? model_mem[widx] : 32'd0;
    end
    e.data = model_rdata;
    sb.push_back(e);
  endtask

  task automatic release_bus();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Issues one request, measures the stall window and checks the RESP cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic scramble, input string name);
    exp_t e;
    int   n;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    push_expect(rd, wr, a, d, name);
    #1;
    n = 0;
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
      if (scramble) begin
        addr      = $urandom;
        wdata     = $urandom;
        mem_read  = 1'b1;
        mem_write = 1'b1;
      end
    end
    checks++;
    if (n !== WAIT_CYCLES + 2) begin
      errors++;
      $display("[TB] FAIL %s stall_cycles: got %0d expected %0d", name, n, WAIT_CYCLES + 2);
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (rd_valid !== e.rv) begin
        errors++;
        $display("[TB] FAIL %s rd_valid: got %0b expected %0b", e.name, rd_valid, e.rv);
      end
      checks++;
      if (fault !== e.flt) begin
        errors++;
        $display("[TB] FAIL %s fault: got %0b expected %0b", e.name, fault, e.flt);
      end
      checks++;
      if (rdata !== e.data) begin
        errors++;
        $display("[TB] FAIL %s rdata: got %08h expected %08h", e.name, rdata, e.data);
      end
    end
  endtask

  task automatic test_reset();
    mem_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stall, rd_valid, fault} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %03b expected 000", {stall, rd_valid, fault});
    end
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %08h expected 00000000", rdata);
    end
    release_bus();
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'd0;
  endtask

  task automatic test_write_read();
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "wr_0x10");
    release_bus();
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "rd_0x10");
    release_bus();
  endtask

  task automatic test_misaligned();
    do_req(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, "rd_0x13");
    release_bus();
    @(negedge clk);
    checks++;
    if ({fault, rd_valid, stall} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL misaligned_after: got %03b expected 000", {fault, rd_valid, stall});
    end
  endtask

  task automatic test_out_of_range();
    do_req(1'b0, 1'b1, 32'h0, 32'hCAFE0000, 1'b0, "wr_0x0");
    release_bus();
    do_req(1'b0, 1'b1, 32'h400, 32'h77, 1'b0, "wr_0x400");
    release_bus();
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "rd_0x0");
    release_bus();
  endtask

  task automatic test_both_ops();
    do_req(1'b1, 1'b1, 32'h20, 32'h5, 1'b0, "rdwr_0x20");
    release_bus();
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "rd_0x20");
    release_bus();
  endtask

  task automatic test_reset_mid_access();
    do_req(1'b0, 1'b1, 32'h30, 32'h1111, 1'b0, "wr_0x30_pre");
    release_bus();
    @(negedge clk);
    mem_write = 1'b1;
    addr      = 32'h30;
    wdata     = 32'h1234;
    @(negedge clk);
    release_bus();
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_wait: got stall=%0b expected 1", stall);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_stall: got %0b expected 0", stall);
    end
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_rdata: got %08h expected 00000000", rdata);
    end
    model_rdata = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, "rd_0x30_after_rst");
    release_bus();
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, 1'b1, 32'h40, 32'hAAAA5555, 1'b0, "wr_0x40_held");
    do_req(1'b0, 1'b1, 32'h44, 32'h9, 1'b0, "wr_0x44_b2b");
    release_bus();
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, "rd_0x40");
    release_bus();
    do_req(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, "rd_0x44");
    release_bus();
  endtask

  // Random words with inputs scrambled during WAIT/RESP to prove the request is latched.
  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'(100 + i) << 2;
      do_req(1'b0, 1'b1, a, $urandom, 1'b1, "rand_wr");
      release_bus();
    end
    for (int i = 3; i >= 0; i--) begin
      a = 32'(100 + i) << 2;
      do_req(1'b1, 1'b0, a, 32'h0, 1'b1, "rand_rd");
      release_bus();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_both_ops();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
